// File: rtl/seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// seq_gen_pkg
// Shared definitions for the serial sequence generator:
//   - state_e   : FSM state encoding (IDLE / SHIFT / PARITY / GAP)
//   - STATE_W   : width of the state encoding
//   - DEF_*     : default values for the generator parameters
// Optional feature macro used by the generator: SERIAL_SEQ_GEN_PARITY_EN
// -----------------------------------------------------------------------------
package seq_gen_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } state_e;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int DEF_REP_W      = 4;

endpackage

// File: rtl/serial_seq_gen_piso_shift_reg.sv
// -----------------------------------------------------------------------------
// piso_shift_reg
// Parallel-in / serial-out shift register, shifting toward the MSB.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  synchronous active-low reset (clears the register)
//   load  in  load d (has priority over shift)
//   shift in  shift left by one, zero fill
//   d     in  parallel load value
//   msb   out current most significant bit
// -----------------------------------------------------------------------------
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= d;
    end else if (shift) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_seq_gen.sv
// -----------------------------------------------------------------------------
// serial_seq_gen
// Serial bit-pattern transmitter. A word accepted over a valid/ready handshake
// is sent MSB-first, one bit per clock, repeated rep_in times (0 means once)
// with GAP_CYCLES idle cycles between repeats.
//
// Handshake: a word is taken at a rising edge where data_valid and data_ready
// are both high; data_ready is only high in IDLE, so data_valid while busy is
// ignored and data_in/rep_in may change freely during a transmission.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset
//   data_in    in   word to transmit (WIDTH)
//   data_valid in   data_in/rep_in valid
//   data_ready out  block can accept a word
//   rep_in     in   number of transmissions (REP_W), 0 treated as 1
//   out        out  serial bit
//   out_valid  out  out carries a payload bit
//   busy       out  transmission in progress
//   done       out  one-cycle pulse in the first IDLE cycle after the last bit
//   dbg_state  out  current FSM state
// All outputs are registered.
//
// Optional feature: define SERIAL_SEQ_GEN_PARITY_EN to append an even-parity
// bit (with out_valid high) after each repetition.
// -----------------------------------------------------------------------------
module serial_seq_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int REP_W      = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [REP_W-1:0] rep_in,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output state_e           dbg_state
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_e             state_q, state_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  logic               sr_load, sr_shift, sr_msb;
  logic [WIDTH-1:0]   sr_d;
  logic               rep_end, reload;

  // The shift register is loaded one bit ahead (word << 1): the MSB goes
  // straight into out_q at the load edge, and sr_msb then already holds the
  // next bit to register.
  piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .d     (sr_d),
    .msb   (sr_msb)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    hold_d      = hold_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    ready_d     = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_d        = {hold_q[WIDTH-2:0], 1'b0};
    rep_end     = 1'b0;
    reload      = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (data_valid && ready_q) begin
          state_d     = SHIFT;
          hold_d      = data_in;
          sr_load     = 1'b1;
          sr_d        = {data_in[WIDTH-2:0], 1'b0};
          rep_cnt_d   = (rep_in == '0) ? REP_W'(1) : rep_in;
          bit_cnt_d   = '0;
          out_d       = data_in[WIDTH-1];
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          ready_d     = 1'b0;
        end
      end
      SHIFT: begin
        // bit_cnt_q is the index (from the MSB) of the bit currently on out.
        if (bit_cnt_q != BIT_LAST) begin
          bit_cnt_d   = bit_cnt_q + BIT_W'(1);
          out_d       = sr_msb;
          out_valid_d = 1'b1;
          sr_shift    = 1'b1;
        end else begin
`ifdef SERIAL_SEQ_GEN_PARITY_EN
          state_d     = PARITY;
          out_d       = ^hold_q;
          out_valid_d = 1'b1;
`else
          rep_end     = 1'b1;
`endif
        end
      end
`ifdef SERIAL_SEQ_GEN_PARITY_EN
      PARITY: begin
        rep_end = 1'b1;
      end
`endif
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          reload = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // End of one repetition: either finish, pause, or restart immediately.
    if (rep_end) begin
      rep_cnt_d = rep_cnt_q - REP_W'(1);
      if (rep_cnt_q == REP_W'(1)) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        ready_d = 1'b1;
      end else if (GAP_CYCLES > 0) begin
        state_d   = GAP;
        gap_cnt_d = '0;
      end else begin
        reload = 1'b1;
      end
    end

    // Restart the word from the hold copy with no bubble.
    if (reload) begin
      state_d     = SHIFT;
      sr_load     = 1'b1;
      bit_cnt_d   = '0;
      out_d       = hold_q[WIDTH-1];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      hold_q      <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      hold_q      <= hold_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign data_ready = ready_q;
  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_serial_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_serial_seq_gen
// Directed bench for serial_seq_gen (WIDTH=8, GAP_CYCLES=2, REP_W=4).
// Expected serial streams are built from the data word into exp_q and checked
// cycle by cycle. Parity expectations follow SERIAL_SEQ_GEN_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_serial_seq_gen;
  import seq_gen_pkg::*;

  localparam int WIDTH      = 8;
  localparam int GAP_CYCLES = 2;
  localparam int REP_W      = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic [REP_W-1:0] rep_in;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;
  state_e           dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  serial_seq_gen #(
    .WIDTH      (WIDTH),
    .GAP_CYCLES (GAP_CYCLES),
    .REP_W      (REP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .rep_in     (rep_in),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Present a word for one edge; data_valid is left high for the caller.
  task automatic accept(input logic [WIDTH-1:0] d, input logic [REP_W-1:0] rep);
    data_in    = d;
    rep_in     = rep;
    data_valid = 1'b1;
    step();
  endtask

  // Called in the first cycle after acceptance; returns in the done cycle.
  task automatic expect_stream(input logic [WIDTH-1:0] d, input int nreps, input string tag);
    logic [1:0] exp_q[$];
    logic [1:0] e;
    int         cyc;
    for (int r = 0; r < nreps; r++) begin
      for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back({1'b1, d[i]});
`ifdef SERIAL_SEQ_GEN_PARITY_EN
      exp_q.push_back({1'b1, ^d});
`endif
      if (r < nreps - 1)
        for (int g = 0; g < GAP_CYCLES; g++) exp_q.push_back(2'b00);
    end
    cyc = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_vld"}, out_valid, e[1]);
      check_eq({tag, "_bit"}, out, e[0]);
      check_eq({tag, "_busy"}, busy, 1'b1);
      check_eq({tag, "_done_lo"}, done, 1'b0);
      check_eq({tag, "_rdy_lo"}, data_ready, 1'b0);
      step();
      cyc++;
    end
    check_eq({tag, "_done"}, done, 1'b1);
    check_eq({tag, "_done_rdy"}, data_ready, 1'b1);
    check_eq({tag, "_done_busy"}, busy, 1'b0);
    check_eq({tag, "_done_vld"}, out_valid, 1'b0);
    check_eq({tag, "_done_cyc"}, cyc, (WIDTH + ((dbg_state == IDLE) ? 0 : 0)
`ifdef SERIAL_SEQ_GEN_PARITY_EN
      + 1
`endif
      ) * nreps + GAP_CYCLES * (nreps - 1) + 1);
  endtask

  initial begin
    rst        = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    rep_in     = '0;

    // Reset state
    step();
    step();
    check_eq("rst_out", out, 1'b0);
    check_eq("rst_vld", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_rdy", data_ready, 1'b0);
    check_eq("rst_state", dbg_state, IDLE);
    rst = 1'b1;
    step();
    check_eq("post_rst_rdy", data_ready, 1'b1);

    // Single word, rep 1: 1,0,1,1,0,0,1,0 then done in cycle 9
    accept(8'hB2, 4'd1);
    data_valid = 1'b0;
    expect_stream(8'hB2, 1, "single");
    step();

    // Repeat with gap, data_in/rep_in scrambled while in flight
    accept(8'hB2, 4'd2);
    data_valid = 1'b0;
    data_in    = 8'h00;
    rep_in     = 4'd9;
    expect_stream(8'hB2, 2, "rep2");
    step();

    // rep_in = 0 behaves as a single transmission
    accept(8'h07, 4'd0);
    data_valid = 1'b0;
    expect_stream(8'h07, 1, "rep0");
    step();

    // Maximum repetition count
    accept(8'h5A, 4'd15);
    data_valid = 1'b0;
    expect_stream(8'h5A, 15, "rep15");
    step();

    // Back-to-back: 3C held valid while A5 is busy, taken in A5's done cycle
    accept(8'hA5, 4'd1);
    data_in = 8'h3C;
    rep_in  = 4'd1;
    expect_stream(8'hA5, 1, "b2b_a5");
    step();
    data_valid = 1'b0;
    expect_stream(8'h3C, 1, "b2b_3c");
    step();

    // Reset mid-transmission after three bits
    accept(8'hFF, 4'd3);
    data_valid = 1'b0;
    step();
    step();
    check_eq("mid_bit3", out, 1'b1);
    rst = 1'b0;
    step();
    check_eq("abort_out", out, 1'b0);
    check_eq("abort_vld", out_valid, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_rdy", data_ready, 1'b0);
    rst = 1'b1;
    step();
    check_eq("abort_rel_rdy", data_ready, 1'b1);
    for (int i = 0; i < 12; i++) begin
      check_eq("abort_quiet_vld", out_valid, 1'b0);
      check_eq("abort_quiet_busy", busy, 1'b0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
